sfq_clk_sequencer: RTL and testbench
====================================

Name: sfq_clk_sequencer

Overview:
- Scheduler that issues single-cycle SFQ clock-request pulses to a chain of NUM_STAGES buffer stages.
- Each stage_clk bit drives one stage's clkin SFQ interface send.
- Runs a programmed number of sweeps across the enabled stages, with a minimum idle gap between pulses so consecutive stage clocks stay at least one gate delay (tgate, 14 ps) apart.
- Sits between the bench/top-level control and the SFQ buffer pipeline.

Parameters:
- NUM_STAGES, 4, number of stage clock outputs (2..16).
- GAP, 2, idle cycles inserted after each pulse (0 allowed).
- CNT_W, 8, width of the sweep counter.

Ports:
- clkin  input  1  sequencer clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a burst; sampled only in IDLE.
- burst_len  input  CNT_W  number of full sweeps; latched on accepted start.
- stage_en  input  NUM_STAGES  stage enable mask; latched on accepted start.
- hold  input  1  stall; freezes pulse issue and gap counter.
- stage_clk  output  NUM_STAGES  one-hot, one-cycle clock pulse per stage.
- busy  output  1  high in PULSE and GAP.
- done  output  1  one-cycle completion strobe.
- sweeps_left  output  CNT_W  remaining sweeps, including the current one.

Behaviour:
- Interface: one clock (clkin); reset rst_n is asynchronous, active-low.
- Reset, asserted at any time including mid-burst: state=IDLE, stage_clk=0, busy=0, done=0, sweeps_left=0, gap counter=0, stage index=first stage. All outputs are registered.
- States: IDLE, PULSE, GAP, DONE.
- IDLE, start=1 at edge N:
  - If burst_len==0 or stage_en==0: go to DONE; done=1 in cycle N+1; no pulses.
  - Otherwise: latch mask, set sweeps_left=burst_len, set index to the first enabled stage in sweep order, go to PULSE.
  - First pulse is asserted in cycle N+1 (latency 1).
- PULSE, hold=0: assert stage_clk[index] for exactly one cycle, then:
  - If the pulse was the last enabled stage of the sweep and sweeps_left==1: go to DONE.
  - Else if GAP>0: go to GAP.
  - Else: go directly to PULSE for the next stage.
- PULSE, hold=1: no pulse, state and index unchanged.
- Disabled stages are skipped at zero cycle cost; the index advances to the next enabled stage, wrapping to the start of the sweep order.
- sweeps_left decrements on the cycle after the last enabled stage's pulse of a sweep. It reaches 0 on entering DONE.
- GAP: counts GAP cycles with hold=0; counter frozen while hold=1. On expiry go to PULSE. Pulses are therefore spaced exactly GAP+1 cycles apart when hold stays low.
- DONE: done=1, busy=0 for one cycle, then IDLE. A start in the DONE cycle is ignored; a start the next cycle (IDLE) is accepted.
- start while busy: ignored, no effect on latched values.
- stage_en and burst_len changes during a burst: no effect.
- stage_clk is never multi-hot. It is never asserted outside PULSE.

Optional Feature:
- Macro SFQ_COUNTERFLOW_EN.
- Defined: sweep order is NUM_STAGES-1 down to 0 (counterflow clocking, clock travels opposite to data).
- Undefined: sweep order is 0 up to NUM_STAGES-1 (concurrent flow).
- Skip, wrap and last-stage detection follow the selected order. All timing is identical in both builds.

Test Plan:
- Full burst: NUM_STAGES=4, GAP=2, stage_en=4'b1111, burst_len=2, start at edge 0 -> pulses on stages 0,1,2,3,0,1,2,3 at cycles 1,4,7,10,13,16,19,22; busy=1 for cycles 1-22; sweeps_left 2→1 at cycle 11; done=1 at cycle 23 only.
- Masked/skip: stage_en=4'b0101, burst_len=1 -> stage0 at cycle 1, stage2 at cycle 4, done at cycle 5; stages 1 and 3 never pulse.
- Hold: full-burst setup with hold=1 during cycles 2-4 -> second pulse (stage1) at cycle 7 instead of 4; all later pulses shifted by +3; done at cycle 26.
- Degenerate/ignore: burst_len=0 -> done at cycle 1, no pulses. A start pulsed at cycle 5 of an active burst -> no change to the pulse schedule or sweeps_left.
- Reset mid-burst: rst_n low at cycle 8 of the full burst -> all outputs 0 immediately (asynchronous). After release, a new start produces a pulse on stage0 one cycle later.
- Counterflow build (SFQ_COUNTERFLOW_EN, stage_en=4'b1111, burst_len=1, GAP=0) -> stage3,2,1,0 at cycles 1,2,3,4; done at cycle 5.

Source files
------------

// File: rtl/sfq_clk_sequencer.sv
// SFQ clock-request sequencer: issues one-hot single-cycle stage clocks over programmed sweeps.
// Define SFQ_COUNTERFLOW_EN to sweep from the last stage down to stage 0 (counterflow clocking).
module sfq_clk_sequencer #(
  parameter int NUM_STAGES = 4,
  parameter int GAP        = 2,
  parameter int CNT_W      = 8
) (
  input  logic                  clkin,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_W-1:0]      burst_len,
  input  logic [NUM_STAGES-1:0] stage_en,
  input  logic                  hold,
  output logic [NUM_STAGES-1:0] stage_clk,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      sweeps_left
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int GW    = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP, S_DONE} state_t;

  // Sweep position <-> stage number; the mapping is its own inverse.
  function automatic int ord(input int p);
`ifdef SFQ_COUNTERFLOW_EN
    return NUM_STAGES - 1 - p;
`else
    return p;
`endif
  endfunction

  function automatic logic [IDX_W-1:0] first_en(input logic [NUM_STAGES-1:0] m);
    logic [IDX_W-1:0] r;
    logic [IDX_W-1:0] s;
    r = IDX_W'(ord(0));
    for (int p = NUM_STAGES - 1; p >= 0; p--) begin
      s = IDX_W'(ord(p));
      if (m[s]) r = s;
    end
    return r;
  endfunction

  function automatic logic last_en(input logic [NUM_STAGES-1:0] m, input logic [IDX_W-1:0] idx);
    logic r;
    logic [IDX_W-1:0] s;
    int pos;
    r   = 1'b1;
    pos = ord(int'(idx));
    for (int p = 0; p < NUM_STAGES; p++) begin
      s = IDX_W'(ord(p));
      if (p > pos && m[s]) r = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] next_en(input logic [NUM_STAGES-1:0] m,
                                               input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] r;
    logic [IDX_W-1:0] s;
    logic found;
    int pos;
    r     = first_en(m);
    found = 1'b0;
    pos   = ord(int'(idx));
    for (int p = 0; p < NUM_STAGES; p++) begin
      s = IDX_W'(ord(p));
      if (!found && p > pos && m[s]) begin
        r     = s;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  state_t                state, state_d;
  logic [IDX_W-1:0]      idx, idx_d;
  logic [NUM_STAGES-1:0] mask, mask_d;
  logic [CNT_W-1:0]      sweeps, sweeps_d;
  logic [GW-1:0]         gcnt, gcnt_d;
  logic [NUM_STAGES-1:0] pulse_d;
  logic                  last;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      idx    <= IDX_W'(ord(0));
      mask   <= '0;
      sweeps <= '0;
      gcnt   <= '0;
    end else begin
      state  <= state_d;
      idx    <= idx_d;
      mask   <= mask_d;
      sweeps <= sweeps_d;
      gcnt   <= gcnt_d;
    end
  end

  always_comb begin
    state_d  = state;
    idx_d    = idx;
    mask_d   = mask;
    sweeps_d = sweeps;
    gcnt_d   = gcnt;
    pulse_d  = '0;
    last     = last_en(mask, idx);
    case (state)
      S_IDLE: begin
        if (start) begin
          if (burst_len == '0 || stage_en == '0) begin
            state_d = S_DONE;
          end else begin
            mask_d   = stage_en;
            sweeps_d = burst_len;
            idx_d    = first_en(stage_en);
            gcnt_d   = '0;
            state_d  = S_PULSE;
          end
        end
      end
      S_PULSE: begin
        if (!hold) begin
          pulse_d[idx] = 1'b1;
          if (last && sweeps == CNT_W'(1)) begin
            sweeps_d = '0;
            state_d  = S_DONE;
          end else begin
            if (last) sweeps_d = sweeps - CNT_W'(1);
            idx_d   = next_en(mask, idx);
            state_d = (GAP > 0) ? S_GAP : S_PULSE;
          end
        end
      end
      S_GAP: begin
        if (!hold) begin
          if (gcnt == GAP_LAST) begin
            gcnt_d  = '0;
            state_d = S_PULSE;
          end else begin
            gcnt_d = gcnt + GW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output register stage: every output lands one cycle after the state that produced it.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      stage_clk   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sweeps_left <= '0;
    end else begin
      stage_clk   <= pulse_d;
      busy        <= (state == S_PULSE) || (state == S_GAP);
      done        <= (state == S_DONE);
      sweeps_left <= sweeps;
    end
  end

endmodule

// File: tb/tb_sfq_clk_sequencer.sv
// Directed bench for sfq_clk_sequencer: pulse schedule scoreboard plus busy/done/sweeps_left checks.
module tb_sfq_clk_sequencer;
  localparam int NS = 4;
  localparam int GP = 2;
  localparam int CW = 8;

  logic          clkin = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          hold  = 1'b0;
  logic [CW-1:0] burst_len = '0;
  logic [NS-1:0] stage_en  = '0;
  logic [NS-1:0] stage_clk;
  logic          busy;
  logic          done;
  logic [CW-1:0] sweeps_left;

  typedef struct {int cyc; int stg;} ev_t;
  ev_t sbq[$];
  int checks   = 0;
  int failures = 0;

  sfq_clk_sequencer #(.NUM_STAGES(NS), .GAP(GP), .CNT_W(CW)) dut (
    .clkin(clkin), .rst_n(rst_n), .start(start), .burst_len(burst_len),
    .stage_en(stage_en), .hold(hold), .stage_clk(stage_clk), .busy(busy),
    .done(done), .sweeps_left(sweeps_left)
  );

  always #5 clkin = ~clkin;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ord(input int p);
`ifdef SFQ_COUNTERFLOW_EN
    return NS - 1 - p;
`else
    return p;
`endif
  endfunction

  // Expected pulse j lands at 1 + j*(GAP+1), plus hshift for pulses j >= hsplit.
  // poke >= 0 pulses start (with different burst_len/stage_en) during that cycle.
  task automatic run_burst(input string nm, input logic [NS-1:0] en, input int len,
                           input int hf, input int ht, input int hsplit, input int hshift,
                           input int poke);
    int stg_list[$];
    int last_pc[$];
    int nen, len_eff, npulse, pc, done_cyc, rel, exp_sw;
    logic [NS-1:0] exp_clk;
    ev_t ev;
    pc = 0;
    for (int p = 0; p < NS; p++) if (en[ord(p)]) stg_list.push_back(ord(p));
    nen     = stg_list.size();
    len_eff = (nen == 0) ? 0 : len;
    npulse  = nen * len_eff;
    for (int j = 0; j < npulse; j++) begin
      pc = 1 + j * (GP + 1) + ((j >= hsplit) ? hshift : 0);
      ev.cyc = pc;
      ev.stg = stg_list[j % nen];
      sbq.push_back(ev);
      if (j % nen == nen - 1) last_pc.push_back(pc);
    end
    done_cyc = (npulse == 0) ? 1 : pc + 1;

    stage_en  = en;
    burst_len = CW'(len);
    start     = 1'b1;
    rel       = -1;
    while (rel < done_cyc + 2) begin
      @(posedge clkin);
      rel++;
      #1;
      start = (rel == poke);
      if (rel == poke) begin
        burst_len = CW'(7);
        stage_en  = NS'(1);
      end
      hold = (rel >= hf && rel <= ht);
      @(negedge clkin);
      exp_clk = '0;
      if (sbq.size() > 0 && sbq[0].cyc == rel) begin
        ev = sbq.pop_front();
        exp_clk[ev.stg] = 1'b1;
      end
      check($sformatf("%s stage_clk c%0d", nm, rel), 32'(stage_clk), 32'(exp_clk));
      check($sformatf("%s busy c%0d", nm, rel), 32'(busy),
            32'(npulse > 0 && rel >= 1 && rel <= done_cyc - 1));
      check($sformatf("%s done c%0d", nm, rel), 32'(done), 32'(rel == done_cyc));
      if (rel >= 1 && rel <= done_cyc) begin
        exp_sw = len_eff;
        foreach (last_pc[s]) if (last_pc[s] + 1 <= rel) exp_sw--;
        check($sformatf("%s sweeps_left c%0d", nm, rel), 32'(sweeps_left), 32'(exp_sw));
      end
    end
    hold = 1'b0;
    check($sformatf("%s missed_pulses", nm), 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clkin);
    check("reset stage_clk", 32'(stage_clk), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset sweeps_left", 32'(sweeps_left), 32'd0);
    rst_n = 1'b1;
    @(negedge clkin);

    run_burst("full",   4'b1111, 2, -10, -10, 1, 0, -1);
    run_burst("masked", 4'b0101, 1, -10, -10, 1, 0, -1);
    run_burst("hold",   4'b1111, 2, 2, 4, 1, 3, -1);
    run_burst("len0",   4'b1111, 0, -10, -10, 1, 0, -1);
    run_burst("en0",    4'b0000, 3, -10, -10, 1, 0, -1);
    run_burst("ignore", 4'b1111, 2, -10, -10, 1, 0, 5);
    run_burst("single", 4'b1000, 3, -10, -10, 1, 0, -1);

    // Asynchronous reset in the middle of a burst.
    stage_en  = 4'b1111;
    burst_len = CW'(2);
    start     = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      @(posedge clkin);
      #1 start = 1'b0;
    end
    check("midrst busy_before", 32'(busy), 32'd1);
    check("midrst sweeps_before", 32'(sweeps_left), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("midrst stage_clk", 32'(stage_clk), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst sweeps_left", 32'(sweeps_left), 32'd0);
    @(negedge clkin);
    rst_n = 1'b1;
    @(negedge clkin);
    check("postrst idle busy", 32'(busy), 32'd0);
    run_burst("postrst", 4'b1111, 1, -10, -10, 1, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
